// File: rtl/cksum_if.sv
// Frame-check stream bundle: dibit stream in, done/kill verdict out.
// The master drives the stream, the slave (checker) returns the verdict.
interface cksum_if;
    logic       axiiv;
    logic [1:0] axiid;
    logic       done;
    logic       kill;

    modport master (
        output axiiv,
        output axiid,
        input  done,
        input  kill
    );

    modport slave (
        input  axiiv,
        input  axiid,
        output done,
        output kill
    );
endinterface

// File: rtl/cksum.sv
// Ethernet FCS checker on a 2-bit RMII-style stream.
// Runs CRC-32 over payload+FCS and compares the register to the residue.
module cksum #(
    parameter logic [31:0] RESIDUE = 32'hC704_DD7B
) (
    input logic clk,
    input logic rst,
    cksum_if.slave bus
);
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
    localparam logic [4:0]  MIN_DIBITS = 5'd16;

    logic [31:0] crc;
    logic [31:0] crc_nxt;
    logic [4:0]  cnt;
    logic        prev_v;
    logic        done_q;
    logic        kill_q;
    logic        frame_end;
    logic        bad;

    function automatic logic [31:0] step(
        input logic [31:0] r,
        input logic        b
    );
        logic fb;
        fb = r[31] ^ b;
        return {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    endfunction

    // axiid[0] is the earlier wire bit, so it goes through first
    assign crc_nxt   = step(step(crc, bus.axiid[0]), bus.axiid[1]);
    assign frame_end = prev_v & ~bus.axiiv;
    assign bad       = (crc != RESIDUE) | (cnt < MIN_DIBITS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc    <= SEED;
            cnt    <= 5'd0;
            prev_v <= 1'b0;
            done_q <= 1'b0;
            kill_q <= 1'b0;
        end else begin
            prev_v <= bus.axiiv;
            done_q <= frame_end;
            kill_q <= frame_end & bad;
            if (bus.axiiv) begin
                crc <= crc_nxt;
                if (cnt < MIN_DIBITS)
                    cnt <= cnt + 5'd1;
            end else begin
                crc <= SEED;
                cnt <= 5'd0;
            end
        end
    end

    assign bus.done = done_q;
    assign bus.kill = kill_q;
endmodule

// File: tb/tb_cksum.sv
// Scoreboard bench for cksum: driver queues verdicts from a bit-serial model,
// a negedge monitor pops and compares them when done pulses.
module tb_cksum;
    localparam logic [31:0] RES  = 32'hC704_DD7B;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    typedef struct {
        int due;
        bit kill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;
    int   ndone = 0;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    bit   [1:0] frame_q[$];

    cksum_if bus();

    cksum #(.RESIDUE(RES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (rst) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check("done_missing", 32'(bus.done), 32'd1);
                void'(exp_q.pop_front());
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_latency", 32'(cyc), 32'(e.due));
                    check("kill_verdict", 32'(bus.kill), 32'(e.kill));
                end
            end else begin
                check("kill_idle", 32'(bus.kill), 32'd0);
            end
        end
    end

    // Reflected byte-wise CRC-32 used only to build a correct FCS
    function automatic logic [31:0] std_crc();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (byte_q[i]) begin
            c = c ^ {24'h0, byte_q[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic append_fcs();
        logic [31:0] f;
        f = std_crc();
        for (int k = 0; k < 4; k++)
            byte_q.push_back(f[8*k +: 8]);
    endtask

    task automatic bytes_to_frame();
        frame_q.delete();
        foreach (byte_q[i])
            for (int k = 0; k < 4; k++)
                frame_q.push_back(byte_q[i][2*k +: 2]);
    endtask

    task automatic load_good(input bit corrupt);
        byte_q.delete();
        for (int i = 0; i < 9; i++)
            byte_q.push_back(8'h31 + 8'(i));
        byte_q.push_back(8'h26);
        byte_q.push_back(8'h39);
        byte_q.push_back(8'hF4);
        byte_q.push_back(8'hCB);
        if (corrupt)
            byte_q[4] = 8'h34;
        bytes_to_frame();
    endtask

    // Reference verdict: serial bit stream through the CRC rule
    function automatic bit model_kill();
        logic [31:0] r;
        bit          b;
        r = 32'hFFFF_FFFF;
        foreach (frame_q[i]) begin
            for (int j = 0; j < 2; j++) begin
                b = frame_q[i][j];
                r = {r[30:0], 1'b0} ^ ((r[31] ^ b) ? POLY : 32'h0);
            end
        end
        return (r != RES) || (frame_q.size() < 16);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.axiiv = 1'b0;
            bus.axiid = 2'($urandom);
        end
    endtask

    // exp < 0 takes the model verdict
    task automatic drive_frame(input int exp, input bit push, input bit rel_rst);
        bit k;
        foreach (frame_q[i]) begin
            @(posedge clk);
            #1;
            if (i == 0 && rel_rst)
                rst = 1'b1;
            bus.axiiv = 1'b1;
            bus.axiid = frame_q[i];
        end
        @(posedge clk);
        #1;
        bus.axiiv = 1'b0;
        bus.axiid = 2'($urandom);
        k = (exp < 0) ? model_kill() : bit'(exp);
        if (push)
            exp_q.push_back('{due: cyc + 1, kill: k});
    endtask

    initial begin
        int d0;
        int sel;
        int n;
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        #23;
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_kill", 32'(bus.kill), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        load_good(1'b0);
        drive_frame(0, 1'b1, 1'b0);
        idle(2);
        load_good(1'b1);
        drive_frame(1, 1'b1, 1'b0);
        idle(2);
        frame_q.delete();
        for (int i = 0; i < 8; i++)
            frame_q.push_back(2'b00);
        drive_frame(1, 1'b1, 1'b0);
        idle(2);

        d0 = ndone;
        load_good(1'b0);
        drive_frame(0, 1'b1, 1'b0);
        load_good(1'b1);
        drive_frame(1, 1'b1, 1'b0);
        idle(3);
        check("b2b_done_count", 32'(ndone - d0), 32'd2);

        // Empty payload: FCS 00000000 gives exactly 16 dibits, a good frame
        byte_q.delete();
        append_fcs();
        bytes_to_frame();
        drive_frame(0, 1'b1, 1'b0);
        idle(1);
        void'(frame_q.pop_back());
        drive_frame(1, 1'b1, 1'b0);
        idle(2);

        // Reset landing on a done pulse, then quiet line
        d0 = ndone;
        load_good(1'b0);
        drive_frame(0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_async_done", 32'(bus.done), 32'd0);
        check("rst_async_kill", 32'(bus.kill), 32'd0);
        idle(2);
        rst = 1'b1;
        idle(5);
        check("rst_no_done", 32'(ndone - d0), 32'd0);

        // Reset mid-frame, released with the next frame already valid
        d0 = ndone;
        load_good(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.axiiv = 1'b1;
            bus.axiid = frame_q[i];
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_done", 32'(bus.done), 32'd0);
        idle(2);
        drive_frame(0, 1'b1, 1'b1);
        idle(3);
        check("midrst_done_count", 32'(ndone - d0), 32'd1);

        for (int f = 0; f < 40; f++) begin
            sel = int'($urandom_range(0, 3));
            byte_q.delete();
            n = int'($urandom_range(0, 24));
            for (int i = 0; i < n; i++)
                byte_q.push_back(8'($urandom));
            if (sel < 3) begin
                append_fcs();
                bytes_to_frame();
                if (sel == 2) begin
                    n = int'($urandom_range(0, frame_q.size() - 1));
                    frame_q[n] = frame_q[n] ^ 2'(1 << $urandom_range(0, 1));
                end
            end else begin
                frame_q.delete();
                n = int'($urandom_range(1, 40));
                for (int i = 0; i < n; i++)
                    frame_q.push_back(2'($urandom));
            end
            drive_frame(-1, 1'b1, 1'b0);
            idle(int'($urandom_range(1, 3)));
        end

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/cksum.md
CKSUM -- requirements
Module: cksum

Interface
REQ-001 Parameter: RESIDUE, default 32'hC704_DD7B, good-frame CRC register residue.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: axiiv  input  1  data valid; high for every dibit of a frame, low between frames.
REQ-005 Port: axiid  input  2  data dibit; axiid[0] is the earlier wire bit, axiid[1] the later.
REQ-006 Port: done  output  1  one-cycle pulse marking frame-check completion.
REQ-007 Port: kill  output  1  frame rejected; meaningful only while done=1.

Function
REQ-008 The block SHALL compute Ethernet CRC-32 over the serial bit stream of a frame.
- The stream is every dibit with axiiv=1, bit axiid[0] first.
- The stream covers payload plus the 32-bit FCS.
REQ-009 CRC register SHALL be 32 bits, shift-left Galois form, polynomial 32'h04C1_1DB7.
- Per bit b: fb = reg[31]^b; reg = {reg[30:0],1'b0} ^ (fb ? 32'h04C1_1DB7 : 0).
- Two bits are processed per valid cycle (axiid[0], then axiid[1]) in one combinational step.
REQ-010 Register SHALL be 32'hFFFF_FFFF whenever axiiv=0.
- The first dibit of a frame is therefore applied to the all-ones seed.
REQ-011 A counter SHALL count valid dibits per frame, saturating at 16 (32 bits).
REQ-012 Frame end is the cycle where axiiv=0 and axiiv was 1 in the previous cycle.
- On the clock edge ending that cycle, done SHALL be registered to 1 for exactly one cycle.
- Done latency: 1 cycle after the first invalid cycle.
REQ-013 kill SHALL be registered to 1 with done when either condition holds:
- the final CRC register differs from RESIDUE, or
- the dibit counter is below 16.
- Otherwise kill SHALL be 0 with done.
REQ-014 kill SHALL be 0 whenever done=0.
REQ-015 A single idle cycle between frames SHALL suffice.
- The next frame's first dibit, in the cycle after the idle cycle, SHALL start from the seed with a zero counter.
- The prior frame's done/kill are unaffected.
REQ-016 Frames of any length SHALL be accepted; there is no upper bound and no internal overflow.
REQ-017 axiid SHALL be ignored while axiiv=0.
REQ-018 Outputs SHALL be driven from flops, with no combinational path from inputs to outputs.

Reset
REQ-019 While rst=0, asynchronously:
- done=0, kill=0;
- CRC register = 32'hFFFF_FFFF;
- dibit counter = 0;
- the registered previous-axiiv = 0.
REQ-020 A frame in progress when rst asserts SHALL be discarded with no done pulse.
- After rst releases, a frame whose axiiv is already high SHALL be processed from its first post-reset dibit.
REQ-021 Reset release needs no synchronisation beyond the rising clock edge; the first edge after rst=1 may accept data.

Verification
REQ-022 Reset: rst=0 mid-activity -> done=0, kill=0 immediately; no done after release while axiiv stays 0.
REQ-023 Good frame: bytes "123456789" (31..39 hex) then FCS bytes 26 39 F4 CB.
- Each byte is sent LSB-first as 4 dibits.
- Required: one cycle after axiiv falls, done=1 and kill=0 for one cycle, then done=0.
REQ-024 Corrupt frame: same as REQ-023 with payload byte 0x35 sent as 0x34.
- Required: done=1, kill=1 for one cycle.
REQ-025 Short frame: 8 valid dibits of 0x00.
- Required: done=1, kill=1 (fewer than 16 dibits).
REQ-026 Back-to-back: good frame, one idle cycle, corrupt frame.
- Required: first done with kill=0, second done with kill=1, and exactly two done pulses.
REQ-027 Reset mid-frame: assert rst after 20 dibits of the good frame, release, send the full good frame.
- Required: exactly one done pulse, with kill=0.
